// File: rtl/vec_dot_product_pipe_acc_pkg.sv
// Shared width helpers, per-stage sideband type and the parameter-check macro
// used by the pipelined dot-product engine.
`ifndef DOT_PRODUCT_PKG_SV
`define DOT_PRODUCT_PKG_SV

// Elaboration-time guard: instantiates a named block that raises $error when cond is false.
`define DP_PARAM_CHECK(label, cond, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end

package dot_product_pkg;

  function automatic int prod_w(input int ew);
    return 2 * ew;
  endfunction

  function automatic int tree_w(input int n, input int ew);
    return prod_w(ew) + $clog2(n);
  endfunction

  typedef struct packed {
    logic valid;
    logic last;
  } stage_side_t;

endpackage

`endif

// File: rtl/vec_dot_product_pipe_acc_if.sv
// Beat-in / result-out bus of the dot-product engine.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready;
// the sender holds its payload stable while valid is high and ready is low.
interface vec_dot_product_pipe_acc_if #(
  parameter int NUM_ELEMENTS  = 8,
  parameter int ELEMENT_WIDTH = 8,
  parameter int ACC_WIDTH     = 27
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_vec_a;
  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_vec_b;
  logic                                  in_last;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [ACC_WIDTH-1:0]                  out_data;
  logic [15:0]                           out_beats;

  modport master (
    output in_valid, in_vec_a, in_vec_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats
  );

  modport slave (
    input  in_valid, in_vec_a, in_vec_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats
  );
endinterface

// File: rtl/vec_dot_product_tree_pipe.sv
// Pipelined N-lane multiply plus registered adder tree with valid/last sideband.
// Usable on its own as a non-accumulating pipelined dot product.
module vec_dot_product_tree_pipe
  import dot_product_pkg::*;
#(
  parameter int NUM_ELEMENTS  = 8,
  parameter int ELEMENT_WIDTH = 8,
  parameter int SIGNED        = 0,
  localparam int PROD_W       = prod_w(ELEMENT_WIDTH),
  localparam int LVLS         = $clog2(NUM_ELEMENTS),
  localparam int TREE_W       = tree_w(NUM_ELEMENTS, ELEMENT_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  in_valid,
  input  logic                                  in_last,
  input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_vec_a,
  input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_vec_b,
  output logic                                  out_valid,
  output logic                                  out_last,
  output logic [TREE_W-1:0]                     out_sum
);

  `DP_PARAM_CHECK(g_bad_num_elements,
                  (NUM_ELEMENTS >= 2) && ((NUM_ELEMENTS & (NUM_ELEMENTS - 1)) == 0),
                  "NUM_ELEMENTS must be a power of two and at least 2")

  // Operands are extended to PROD_W first; the low PROD_W bits of the product are then
  // exact for both two's-complement and unsigned elements.
  function automatic logic [PROD_W-1:0] mul_elem(input logic [ELEMENT_WIDTH-1:0] a,
                                                 input logic [ELEMENT_WIDTH-1:0] b);
    logic [PROD_W-1:0] ea;
    logic [PROD_W-1:0] eb;
    ea = {{ELEMENT_WIDTH{(SIGNED != 0) & a[ELEMENT_WIDTH-1]}}, a};
    eb = {{ELEMENT_WIDTH{(SIGNED != 0) & b[ELEMENT_WIDTH-1]}}, b};
    return ea * eb;
  endfunction

  stage_side_t side_d [LVLS+1];
  stage_side_t side_q [LVLS+1];

  always_comb begin
    side_d[0].valid = in_valid;
    side_d[0].last  = in_last;
    for (int l = 1; l <= LVLS; l++) begin
      side_d[l] = side_q[l-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l <= LVLS; l++) begin
        side_q[l] <= '0;
      end
    end else if (en) begin
      side_q <= side_d;
    end
  end

  // Level 0 holds the products; level l holds NUM_ELEMENTS>>l sums, each one bit wider.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int W   = PROD_W + l;
    localparam int CNT = NUM_ELEMENTS >> l;

    logic [W-1:0] node_d [CNT];
    logic [W-1:0] node_q [CNT];

    if (l == 0) begin : g_mul
      always_comb begin
        for (int j = 0; j < CNT; j++) begin
          node_d[j] = mul_elem(in_vec_a[j*ELEMENT_WIDTH +: ELEMENT_WIDTH],
                               in_vec_b[j*ELEMENT_WIDTH +: ELEMENT_WIDTH]);
        end
      end
    end else begin : g_add
      always_comb begin
        for (int j = 0; j < CNT; j++) begin
          node_d[j] = {(SIGNED != 0) & g_lvl[l-1].node_q[2*j][W-2],   g_lvl[l-1].node_q[2*j]}
                    + {(SIGNED != 0) & g_lvl[l-1].node_q[2*j+1][W-2], g_lvl[l-1].node_q[2*j+1]};
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < CNT; j++) begin
          node_q[j] <= '0;
        end
      end else if (en) begin
        node_q <= node_d;
      end
    end
  end

  assign out_sum   = g_lvl[LVLS].node_q[0];
  assign out_valid = side_q[LVLS].valid;
  assign out_last  = side_q[LVLS].last;

endmodule

// File: rtl/vec_dot_product_pipe_acc.sv
// Pipelined dot-product engine: multiply/adder-tree pipe followed by a frame accumulator
// that emits one result (and its beat count) per in_last-terminated frame.
module vec_dot_product_pipe_acc
  import dot_product_pkg::*;
#(
  parameter int NUM_ELEMENTS  = 8,
  parameter int ELEMENT_WIDTH = 8,
  parameter int SIGNED        = 0,
  parameter int ACC_WIDTH     = 27,
  localparam int TREE_W       = tree_w(NUM_ELEMENTS, ELEMENT_WIDTH)
) (
  input logic                        clk,
  input logic                        rst,
  vec_dot_product_pipe_acc_if.slave  bus
);

  `DP_PARAM_CHECK(g_bad_acc_width, ACC_WIDTH >= TREE_W,
                  "ACC_WIDTH must be at least the adder-tree output width")

  logic                 en;
  logic                 tree_valid;
  logic                 tree_last;
  logic [TREE_W-1:0]    tree_sum;
  logic [ACC_WIDTH-1:0] tree_ext;
  logic [ACC_WIDTH-1:0] frame_sum;
  logic [15:0]          cnt_next;

  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic [ACC_WIDTH-1:0] out_data_d, out_data_q;
  logic [15:0]          cnt_d, cnt_q;
  logic [15:0]          out_beats_d, out_beats_q;
  logic                 first_d, first_q;
  logic                 out_valid_d, out_valid_q;

  // A single advance enable stalls every stage while a result waits for its consumer.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  vec_dot_product_tree_pipe #(
    .NUM_ELEMENTS  (NUM_ELEMENTS),
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .SIGNED        (SIGNED)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (bus.in_valid),
    .in_last   (bus.in_last),
    .in_vec_a  (bus.in_vec_a),
    .in_vec_b  (bus.in_vec_b),
    .out_valid (tree_valid),
    .out_last  (tree_last),
    .out_sum   (tree_sum)
  );

  always_comb begin
    if (SIGNED != 0) begin
      tree_ext = ACC_WIDTH'($signed(tree_sum));
    end else begin
      tree_ext = ACC_WIDTH'(tree_sum);
    end
    frame_sum = (first_q ? '0 : acc_q) + tree_ext;
    if (first_q) begin
      cnt_next = 16'd1;
    end else if (cnt_q == 16'hFFFF) begin
      cnt_next = cnt_q;
    end else begin
      cnt_next = cnt_q + 16'd1;
    end
  end

  // A result completing in the same cycle the old one is taken replaces it without a bubble.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    if (en) begin
      if (out_valid_q) begin
        out_valid_d = 1'b0;
      end
      if (tree_valid) begin
        cnt_d = cnt_next;
        if (tree_last) begin
          out_data_d  = frame_sum;
          out_beats_d = cnt_next;
          out_valid_d = 1'b1;
          first_d     = 1'b1;
        end else begin
          acc_d   = frame_sum;
          first_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_beats = out_beats_q;

endmodule
